// File: rtl/soc_pkg.sv
// Shared types for the SoC memory path: port ownership encoding, the response
// routing tag carried alongside each in-flight memory access, and the default
// memory read latency.
`timescale 1ns/1ps
package soc_pkg;

    localparam int unsigned MEM_LATENCY_DEF = 1;

    // Which arbiter port issued an access.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    // Routing tag for one in-flight access.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Tag shift register matching the memory read latency; the tag leaving the
// last stage selects which port's rvalid pulses for the current mem_rdata.
//   clk        system clock
//   reset_n    asynchronous active-low clear of every stage
//   i_tag      tag for the access granted this cycle (valid=0 when idle)
//   if_rvalid  fetch response valid
//   d_rvalid   data response valid (read data or write acknowledge)
`timescale 1ns/1ps
module arb_tag_pipe
    import soc_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  tag_t i_tag,
    output logic if_rvalid,
    output logic d_rvalid
);

    tag_t r_pipe [DEPTH];
    tag_t w_out;

    // Shift one stage per cycle; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out     = r_pipe[DEPTH-1];
    assign if_rvalid = w_out.valid && (w_out.owner == OWNER_IF);
    assign d_rvalid  = w_out.valid && (w_out.owner == OWNER_D);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the load/store port. Grants are combinational in
// the request cycle; responses are routed back by a tag pipeline so one access
// per cycle can be sustained regardless of memory latency.
//   clk, reset_n                      clock, asynchronous active-low reset
//   if_req/if_addr                    fetch request (read only)
//   if_gnt/if_rvalid/if_rdata         fetch grant and response
//   d_req/d_we/d_be/d_addr/d_wdata    load/store request
//   d_gnt/d_rvalid/d_rdata            data grant and response / write ack
//   mem_en/we/be/addr/wdata/rdata     memory side
`timescale 1ns/1ps
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    owner_e r_last_owner;
    owner_e w_last_owner_nxt;
    logic   w_if_gnt;
    logic   w_d_gnt;
    tag_t   w_tag;

    // Round-robin pointer; DATA after reset so fetch wins the first conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= OWNER_D;
        end else begin
            r_last_owner <= w_last_owner_nxt;
        end
    end

    // Grant selection, pointer update and routing tag for this cycle.
    always_comb begin
        w_if_gnt         = 1'b0;
        w_d_gnt          = 1'b0;
        w_last_owner_nxt = r_last_owner;
        // Grants are forced low while reset is asserted, whatever the requests.
        if (reset_n) begin
            if (if_req && d_req) begin
                if (r_last_owner == OWNER_D) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b1;
                end
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
        if (w_if_gnt) begin
            w_last_owner_nxt = OWNER_IF;
        end else if (w_d_gnt) begin
            w_last_owner_nxt = OWNER_D;
        end
        w_tag.valid = w_if_gnt | w_d_gnt;
        w_tag.owner = w_d_gnt ? OWNER_D : OWNER_IF;
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;

    // Memory drive muxed from the granted port; fetch is always a full-word read.
    assign mem_en    = w_if_gnt | w_d_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_be    = w_if_gnt ? {BE_WIDTH{1'b1}} : (w_d_gnt ? d_be : BE_WIDTH'(0));
    assign mem_addr  = w_d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_wdata;

    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

    arb_tag_pipe #(
        .DEPTH     (MEM_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_tag     (w_tag),
        .if_rvalid (if_rvalid),
        .d_rvalid  (d_rvalid)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic [3:0]  mem_be_1;
    logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_be_3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_be(mem_be_1), .mem_addr(mem_addr_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_be(mem_be_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
    );

    // Memory models: word i preloads to 0xA000_0000 + i while reset is low.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] r1;
    logic [31:0] p3 [3];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= 32'hA000_0000 + 32'(i);
                mem3[i] <= 32'hA000_0000 + 32'(i);
            end
        end else begin
            if (mem_en_1) begin
                if (mem_we_1) mem1[mem_addr_1[7:2]] <= merge(mem1[mem_addr_1[7:2]], mem_wdata_1, mem_be_1);
                r1 <= mem1[mem_addr_1[7:2]];
            end
            if (mem_en_3 && mem_we_3) mem3[mem_addr_3[7:2]] <= merge(mem3[mem_addr_3[7:2]], mem_wdata_3, mem_be_3);
        end
        p3[0] <= mem_en_3 ? mem3[mem_addr_3[7:2]] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign mem_rdata_1 = r1;
    assign mem_rdata_3 = p3[2];

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h0);
        drive(1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'h0);
        n_vec++; if ({if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3} !== 4'b0) begin n_err++; $display("FAIL reset gnts: got %b expected 0000", {if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3}); end
        n_vec++; if ({mem_en_1, mem_we_1, mem_en_3, mem_we_3} !== 4'b0) begin n_err++; $display("FAIL reset mem_en/we: got %b expected 0000", {mem_en_1, mem_we_1, mem_en_3, mem_we_3}); end
        n_vec++; if ({mem_be_1, mem_be_3} !== 8'h00) begin n_err++; $display("FAIL reset mem_be: got %h expected 00", {mem_be_1, mem_be_3}); end
        n_vec++; if ({if_rvalid_1, d_rvalid_1, if_rvalid_3, d_rvalid_3} !== 4'b0) begin n_err++; $display("FAIL reset rvalids: got %b expected 0000", {if_rvalid_1, d_rvalid_1, if_rvalid_3, d_rvalid_3}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_conflict;
        logic [4:0] e_ig  = 5'b00101;
        logic [4:0] e_dg  = 5'b01010;
        logic [4:0] e_irv = 5'b01010;
        logic [4:0] e_drv = 5'b10100;
        for (int c = 0; c < 5; c++) begin
            drive(c < 4, 32'h20, c < 4, 1'b0, 4'hF, 32'h24, 32'h0);
            n_vec++; if ({if_gnt_1, d_gnt_1} !== {e_ig[c], e_dg[c]}) begin n_err++; $display("FAIL conflict gnt lat1 c%0d: got %b expected %b", c, {if_gnt_1, d_gnt_1}, {e_ig[c], e_dg[c]}); end
            n_vec++; if ({if_gnt_3, d_gnt_3} !== {e_ig[c], e_dg[c]}) begin n_err++; $display("FAIL conflict gnt lat3 c%0d: got %b expected %b", c, {if_gnt_3, d_gnt_3}, {e_ig[c], e_dg[c]}); end
            if (c < 4) begin
                n_vec++; if (mem_addr_1 !== (e_ig[c] ? 32'h20 : 32'h24)) begin n_err++; $display("FAIL conflict mem_addr c%0d: got %h expected %h", c, mem_addr_1, e_ig[c] ? 32'h20 : 32'h24); end
            end
            n_vec++; if ({if_rvalid_1, d_rvalid_1} !== {e_irv[c], e_drv[c]}) begin n_err++; $display("FAIL conflict rvalid c%0d: got %b expected %b", c, {if_rvalid_1, d_rvalid_1}, {e_irv[c], e_drv[c]}); end
            if (e_irv[c]) begin
                n_vec++; if (if_rdata_1 !== 32'hA000_0008) begin n_err++; $display("FAIL conflict if_rdata c%0d: got %h expected a0000008", c, if_rdata_1); end
            end
            if (e_drv[c]) begin
                n_vec++; if (d_rdata_1 !== 32'hA000_0009) begin n_err++; $display("FAIL conflict d_rdata c%0d: got %h expected a0000009", c, d_rdata_1); end
            end
        end
        idle(3);
    endtask

    task automatic test_fetch_only;
        for (int c = 0; c < 4; c++) begin
            drive(c < 3, 32'(c * 4), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            n_vec++; if (if_gnt_1 !== (c < 3)) begin n_err++; $display("FAIL fetch if_gnt c%0d: got %b expected %b", c, if_gnt_1, c < 3); end
            if (c < 3) begin
                n_vec++; if ({mem_we_1, mem_be_1} !== 5'b0_1111) begin n_err++; $display("FAIL fetch mem_we/be c%0d: got %b expected 01111", c, {mem_we_1, mem_be_1}); end
            end
            n_vec++; if (if_rvalid_1 !== (c >= 1)) begin n_err++; $display("FAIL fetch if_rvalid c%0d: got %b expected %b", c, if_rvalid_1, c >= 1); end
            if (c >= 1) begin
                n_vec++; if (if_rdata_1 !== 32'hA000_0000 + 32'(c - 1)) begin n_err++; $display("FAIL fetch if_rdata c%0d: got %h expected %h", c, if_rdata_1, 32'hA000_0000 + 32'(c - 1)); end
            end
            n_vec++; if (d_rvalid_1 !== 1'b0) begin n_err++; $display("FAIL fetch d_rvalid c%0d: got %b expected 0", c, d_rvalid_1); end
        end
        idle(3);
    endtask

    task automatic test_store_load;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEAD_BEEF);
        n_vec++; if ({d_gnt_1, mem_we_1, mem_be_1} !== 6'b11_0011) begin n_err++; $display("FAIL store gnt/we/be: got %b expected 110011", {d_gnt_1, mem_we_1, mem_be_1}); end
        n_vec++; if ({mem_addr_1, mem_wdata_1} !== {32'h10, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL store addr/wdata: got %h expected 00000010deadbeef", {mem_addr_1, mem_wdata_1}); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        n_vec++; if ({d_gnt_1, mem_we_1, d_rvalid_1} !== 3'b101) begin n_err++; $display("FAIL load gnt/we/ack: got %b expected 101", {d_gnt_1, mem_we_1, d_rvalid_1}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if (d_rvalid_1 !== 1'b1) begin n_err++; $display("FAIL load d_rvalid: got %b expected 1", d_rvalid_1); end
        n_vec++; if (d_rdata_1 !== 32'hA000_BEEF) begin n_err++; $display("FAIL load d_rdata: got %h expected a000beef", d_rdata_1); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if ({if_rvalid_1, d_rvalid_1} !== 2'b00) begin n_err++; $display("FAIL load rvalid tail: got %b expected 00", {if_rvalid_1, d_rvalid_1}); end
        idle(2);
    endtask

    task automatic test_back_to_back_lat3;
        logic [8:0]  v_ir  = 9'b000011101;
        logic [8:0]  v_dr  = 9'b000111110;
        logic [8:0]  v_dw  = 9'b000110000;
        logic [8:0]  e_ig  = 9'b000010101;
        logic [8:0]  e_dg  = 9'b000101010;
        logic [8:0]  e_irv = 9'b010101000;
        logic [8:0]  e_drv = 9'b101010000;
        logic [31:0] ia, da, ed;
        for (int c = 0; c < 9; c++) begin
            case (c)
                0: begin ia = 32'h00; da = 32'h00; end
                1: begin ia = 32'h00; da = 32'h10; end
                2: begin ia = 32'h04; da = 32'h14; end
                3: begin ia = 32'h08; da = 32'h14; end
                default: begin ia = 32'h08; da = 32'h18; end
            endcase
            case (c)
                3: ed = 32'hA000_0000;
                4: ed = 32'hA000_BEEF;
                5: ed = 32'hA000_0001;
                6: ed = 32'hA000_0005;
                7: ed = 32'hA000_0002;
                default: ed = 32'h0;
            endcase
            drive(v_ir[c], ia, v_dr[c], v_dw[c], 4'hF, da, 32'h1234_5678);
            n_vec++; if ({if_gnt_3, d_gnt_3} !== {e_ig[c], e_dg[c]}) begin n_err++; $display("FAIL b2b gnt c%0d: got %b expected %b", c, {if_gnt_3, d_gnt_3}, {e_ig[c], e_dg[c]}); end
            n_vec++; if ({if_rvalid_3, d_rvalid_3} !== {e_irv[c], e_drv[c]}) begin n_err++; $display("FAIL b2b rvalid c%0d: got %b expected %b", c, {if_rvalid_3, d_rvalid_3}, {e_irv[c], e_drv[c]}); end
            if (e_irv[c]) begin
                n_vec++; if (if_rdata_3 !== ed) begin n_err++; $display("FAIL b2b if_rdata c%0d: got %h expected %h", c, if_rdata_3, ed); end
            end
            if (e_drv[c] && c != 8) begin
                n_vec++; if (d_rdata_3 !== ed) begin n_err++; $display("FAIL b2b d_rdata c%0d: got %h expected %h", c, d_rdata_3, ed); end
            end
        end
    endtask

    task automatic test_reset_midflight;
        drive(1'b1, 32'h0C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if ({if_gnt_1, if_gnt_3} !== 2'b11) begin n_err++; $display("FAIL midflight first gnt: got %b expected 11", {if_gnt_1, if_gnt_3}); end
        @(posedge clk); #1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h24;
        reset_n = 1'b0;
        #1;
        n_vec++; if ({if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3, mem_en_1, mem_en_3} !== 6'b0) begin n_err++; $display("FAIL midflight gnt/en in reset: got %b expected 000000", {if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3, mem_en_1, mem_en_3}); end
        n_vec++; if ({if_rvalid_1, if_rvalid_3} !== 2'b00) begin n_err++; $display("FAIL midflight rvalid in reset: got %b expected 00", {if_rvalid_1, if_rvalid_3}); end
        reset_n = 1'b1;
        drive(1'b1, 32'h0C, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        n_vec++; if (if_rvalid_1 !== 1'b0) begin n_err++; $display("FAIL midflight dropped if_rvalid lat1: got %b expected 0", if_rvalid_1); end
        n_vec++; if ({if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3} !== 4'b1010) begin n_err++; $display("FAIL midflight conflict winner: got %b expected 1010", {if_gnt_1, d_gnt_1, if_gnt_3, d_gnt_3}); end
        drive(1'b1, 32'h0C, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        n_vec++; if ({if_gnt_1, d_gnt_1, if_rvalid_1} !== 3'b011) begin n_err++; $display("FAIL midflight second gnt/rvalid: got %b expected 011", {if_gnt_1, d_gnt_1, if_rvalid_1}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if (if_rvalid_3 !== 1'b0) begin n_err++; $display("FAIL midflight dropped if_rvalid lat3: got %b expected 0", if_rvalid_3); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if ({if_rvalid_3, d_rvalid_3, if_rdata_3} !== {2'b10, 32'hA000_0003}) begin n_err++; $display("FAIL midflight lat3 fetch resp: got %h expected 2a0000003", {if_rvalid_3, d_rvalid_3, if_rdata_3}); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        n_vec++; if ({if_rvalid_3, d_rvalid_3, d_rdata_3} !== {2'b01, 32'hA000_0009}) begin n_err++; $display("FAIL midflight lat3 data resp: got %h expected 1a0000009", {if_rvalid_3, d_rvalid_3, d_rdata_3}); end
    endtask

    task automatic test_idle;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h40, 1'b0, 1'b1, 4'hF, 32'h44, 32'hFFFF_FFFF);
            n_vec++; if ({mem_en_1, mem_we_1, mem_be_1, mem_en_3, mem_we_3, mem_be_3} !== 12'h000) begin n_err++; $display("FAIL idle mem strobes c%0d: got %h expected 000", c, {mem_en_1, mem_we_1, mem_be_1, mem_en_3, mem_we_3, mem_be_3}); end
            n_vec++; if ({if_rvalid_1, d_rvalid_1, if_rvalid_3, d_rvalid_3} !== 4'b0) begin n_err++; $display("FAIL idle rvalids c%0d: got %b expected 0000", c, {if_rvalid_1, d_rvalid_1, if_rvalid_3, d_rvalid_3}); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_conflict();
        test_fetch_only();
        test_store_load();
        test_back_to_back_lat3();
        test_reset_midflight();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the SoC's single-port synchronous memory between the CPU instruction-fetch port and the load/store (data) port. It sits between `cpu_inst` and the memory inside `soc` and applies round-robin arbitration when both ports request in the same cycle. It carries up to MEM_LATENCY in-flight accesses and routes each response back to the port that issued it, so the pipeline sustains one access per cycle.

## Interface
- ADDR_WIDTH, 32, byte-address width on all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits wide
- MEM_LATENCY, 1, cycles from the memory-enable edge to valid `mem_rdata`; legal range 1..4

- clk  in  1  system clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_WIDTH/8  byte enables, writes only
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  read data valid, or write completion acknowledge
- d_rdata  out  DATA_WIDTH  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after `mem_en`

## Operation
Grant:
- Grants are combinational in the cycle of the request. At most one of `if_gnt`/`d_gnt` is high in any cycle.
- A request is accepted only when req and gnt are both high at a clock edge. A requester keeps its address and data stable until granted.

Arbitration:
- Only one port requesting: that port is granted.
- Both ports requesting: the port that was not granted most recently wins.
- `last_owner` updates only on an edge where a grant occurs.
- `last_owner` resets to DATA, so fetch wins the first conflict after reset.

Memory drive:
- `mem_en` = `if_gnt | d_gnt`.
- Address, we, be and wdata are muxed from the granted port.
- A fetch grant drives `mem_we` = 0 and `mem_be` = all ones.
- With no grant, `mem_we` and `mem_be` are 0. Address and wdata are don't-care.

Tag pipeline:
- Each granted access pushes a tag {valid, owner} into a shift register of depth MEM_LATENCY.
- When a valid tag exits, the owner's rvalid is asserted for exactly one cycle.
- Both rdata outputs are wired to `mem_rdata`; only the matching rvalid qualifies them.

Writes:
- Writes also produce a `d_rvalid` pulse, MEM_LATENCY cycles after the grant. The accompanying `d_rdata` is undefined.

Reset:
- While `reset_n` = 0: all tags cleared and `last_owner` = DATA.
- During reset, gnts, rvalids, `mem_en`, `mem_we` and `mem_be` are 0, regardless of the req inputs.
- Reset asserted mid-operation drops every in-flight access. No rvalid is produced for it after release.

## Timing
- Throughput: one access per cycle when requests are continuous, independent of MEM_LATENCY.
- Grant-to-rvalid latency: grant at edge t gives rvalid high during the cycle after edge t+MEM_LATENCY-1, i.e. exactly MEM_LATENCY cycles after the grant cycle.
- A grant may coincide with a response to either port in the same cycle.
- Continuous conflict: grants strictly alternate, fetch first after reset. Neither port waits more than 1 cycle.
- Reset release: a request present in the first cycle with `reset_n` = 1 may be granted in that cycle.
- No combinational path exists from `mem_rdata` to any gnt.

## Structure
- Shared package `soc_pkg`:
  - owner encoding OWNER_IF = 1'b0, OWNER_D = 1'b1
  - tag struct {valid, owner}
  - MEM_LATENCY default constant
- Sub-module `arb_tag_pipe`: parameterised-depth tag shift register with asynchronous clear. Outputs `if_rvalid` and `d_rvalid`.
- Top level holds the round-robin pointer and the muxes.

## Test plan
- Fetch only: `if_req` held high with addresses 0x0, 0x4, 0x8 on consecutive cycles (MEM_LATENCY = 1). Expect `if_gnt` high every cycle, `if_rvalid` in cycles 1, 2, 3 with the matching memory words, and `d_rvalid` never high.
- Conflict after reset: `if_req` and `d_req` both high for 4 cycles. Expect grants IF, D, IF, D. Each rvalid appears on the correct port 1 cycle after its grant.
- Store then load: `d_we` = 1, `d_be` = 4'b0011, addr 0x10, wdata 0xDEADBEEF; then a read of 0x10. Expect a write ack `d_rvalid`, then `d_rdata` = 0xXXXXBEEF with the upper half preserved from the prior contents.
- MEM_LATENCY = 3 with back-to-back mixed requests. Expect each rvalid exactly 3 cycles after its grant, in issue order, with no gaps in grants.
- Reset mid-flight: grant a fetch, then pulse `reset_n` low for 1 time unit before its response. Expect no `if_rvalid`, all gnts 0 during reset, and the next conflict won by fetch.
- Idle: no requests. Expect `mem_en`, `mem_we` and `mem_be` all 0 and no rvalid.
